// File: rtl/timer_pkg.sv
// Shared types, constants and helpers for the BCD second timer.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StDone   = 2'd3
  } timer_state_e;

  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam logic [3:0] TERM_UP_TENS   = 4'd9;
  localparam logic [3:0] TERM_UP_ONES   = 4'd9;
  localparam logic [3:0] TERM_DOWN_TENS = 4'd0;
  localparam logic [3:0] TERM_DOWN_ONES = 4'd0;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic logic is_terminal(input logic [3:0] tens, input logic [3:0] ones,
                                       input logic up);
    if (up) return (tens == TERM_UP_TENS) && (ones == TERM_UP_ONES);
    else    return (tens == TERM_DOWN_TENS) && (ones == TERM_DOWN_ONES);
  endfunction

  // tens*10 + ones as tens*8 + tens*2 + ones
  function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] t7;
    t7 = {3'b000, tens};
    return (t7 << 3) + (t7 << 1) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Single-cycle pulse on each rising edge of a slow level input sampled in the clk_in domain.
module rise_edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic pulse_out
);

  logic prev;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= sig_in;
  end

  assign pulse_out = sig_in & ~prev;

endmodule

// File: rtl/bcd_second_timer.sv
// Two-digit BCD up/down seconds counter stepped by rising edges of the divider output.
module bcd_second_timer
  import timer_pkg::*;
#(
  parameter bit          AUTO_RELOAD = 1'b0,
  parameter int unsigned BIN_W       = 7
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             divided_clk,
  input  logic             load,
  input  logic [3:0]       preset_tens,
  input  logic [3:0]       preset_ones,
  input  logic             up_down,
  input  logic             start,
  input  logic             pause,
  output logic [3:0]       tens_out,
  output logic [3:0]       ones_out,
  output logic [BIN_W-1:0] bin_out,
  output logic             running,
  output logic             done
);

  timer_state_e     state_q, state_d;
  logic [3:0]       tens_q, tens_d, ones_q, ones_d;
  logic [3:0]       pre_tens_q, pre_tens_d, pre_ones_q, pre_ones_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             tick;

  rise_edge_detect u_edge (
    .clk_in    (clk_in),
    .rst       (rst),
    .sig_in    (divided_clk),
    .pulse_out (tick)
  );

  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    pre_tens_d = pre_tens_q;
    pre_ones_d = pre_ones_q;
    dir_d      = dir_q;
    done_d     = 1'b0;

    if (load) begin
      state_d    = StIdle;
      tens_d     = clamp_digit(preset_tens);
      ones_d     = clamp_digit(preset_ones);
      pre_tens_d = clamp_digit(preset_tens);
      pre_ones_d = clamp_digit(preset_ones);
    end else if (pause) begin
      if (state_q == StRun) state_d = StPaused;
    end else if (start) begin
      unique case (state_q)
        StIdle: begin
          dir_d = up_down;
          if (is_terminal(tens_q, ones_q, up_down)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
        StPaused: begin
          dir_d   = up_down;
          state_d = StRun;
        end
        default: ;
      endcase
    end else if (tick && (state_q == StRun)) begin
      // With auto-reload, a tick while sitting on the terminal restarts from the preset
      if (AUTO_RELOAD && is_terminal(tens_q, ones_q, dir_q)) begin
        tens_d = pre_tens_q;
        ones_d = pre_ones_q;
      end else begin
        if (dir_q) begin
          if (ones_q != BCD_MAX) begin
            ones_d = ones_q + 4'd1;
          end else begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end
        end else begin
          if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else begin
            ones_d = BCD_MAX;
            tens_d = tens_q - 4'd1;
          end
        end
        if (is_terminal(tens_d, ones_d, dir_q)) begin
          done_d = 1'b1;
          if (!AUTO_RELOAD) state_d = StDone;
        end
      end
    end

    bin_d = BIN_W'(bcd_to_bin(tens_d, ones_d));
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      pre_tens_q <= 4'd0;
      pre_ones_q <= 4'd0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      bin_q      <= '0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      pre_tens_q <= pre_tens_d;
      pre_ones_q <= pre_ones_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      bin_q      <= bin_d;
    end
  end

  assign tens_out = tens_q;
  assign ones_out = ones_q;
  assign bin_out  = bin_q;
  assign running  = (state_q == StRun);
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_second_timer.sv
// Directed bench for bcd_second_timer: vector table plus multi-cycle terminal/reload sequences.
module tb_bcd_second_timer;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       divided_clk = 1'b0;
  logic       load = 1'b0;
  logic [3:0] preset_tens = 4'd0;
  logic [3:0] preset_ones = 4'd0;
  logic       up_down = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;

  logic [3:0] tens0, ones0, tens1, ones1;
  logic [6:0] bin0, bin1;
  logic       run0, run1, done0, done1;

  int total = 0;
  int passed = 0;

  always #5 clk_in = ~clk_in;

  bcd_second_timer #(.AUTO_RELOAD(1'b0), .BIN_W(7)) dut0 (
    .clk_in(clk_in), .rst(rst), .divided_clk(divided_clk), .load(load),
    .preset_tens(preset_tens), .preset_ones(preset_ones), .up_down(up_down),
    .start(start), .pause(pause), .tens_out(tens0), .ones_out(ones0),
    .bin_out(bin0), .running(run0), .done(done0)
  );

  bcd_second_timer #(.AUTO_RELOAD(1'b1), .BIN_W(7)) dut1 (
    .clk_in(clk_in), .rst(rst), .divided_clk(divided_clk), .load(load),
    .preset_tens(preset_tens), .preset_ones(preset_ones), .up_down(up_down),
    .start(start), .pause(pause), .tens_out(tens1), .ones_out(ones1),
    .bin_out(bin1), .running(run1), .done(done1)
  );

  typedef struct {
    logic       ld;
    logic [3:0] pt;
    logic [3:0] po;
    logic       up;
    logic       st;
    logic       pa;
    logic       tk;
    logic [3:0] et;
    logic [3:0] eo;
    logic [6:0] eb;
    logic       er;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ld, logic [3:0] pt, logic [3:0] po, logic up, logic st,
                              logic pa, logic tk, logic [3:0] et, logic [3:0] eo,
                              logic [6:0] eb, logic er, logic ed);
    vec_t v;
    v.ld = ld; v.pt = pt; v.po = po; v.up = up; v.st = st; v.pa = pa; v.tk = tk;
    v.et = et; v.eo = eo; v.eb = eb; v.er = er; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk0(input string name, input int t, input int o, input int r, input int d);
    chk({name, " tens"}, int'(tens0), t);
    chk({name, " ones"}, int'(ones0), o);
    chk({name, " bin"}, int'(bin0), t * 10 + o);
    chk({name, " running"}, int'(run0), r);
    chk({name, " done"}, int'(done0), d);
  endtask

  task automatic chk1(input string name, input int t, input int o, input int r, input int d);
    chk({name, " ar tens"}, int'(tens1), t);
    chk({name, " ar ones"}, int'(ones1), o);
    chk({name, " ar running"}, int'(run1), r);
    chk({name, " ar done"}, int'(done1), d);
  endtask

  task automatic tick_hi();
    divided_clk = 1'b1;
    step();
  endtask

  task automatic tick_lo();
    repeat (2) step();
    divided_clk = 1'b0;
    repeat (4) step();
  endtask

  task automatic pulse_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; preset_tens = t; preset_ones = o;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_start(input logic up);
    start = 1'b1; up_down = up;
    step();
    start = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #2;
    chk0("reset", 0, 0, 0, 0);
    chk1("reset", 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // Reset asserted mid-RUN must clear outputs without a clock edge
    pulse_load(4'd3, 4'd5);
    pulse_start(1'b0);
    tick_hi();
    chk0("first tick", 3, 4, 1, 0);
    rst = 1'b1;
    #2;
    chk0("async rst", 0, 0, 0, 0);
    rst = 1'b0;
    step();
    divided_clk = 1'b0;
    step();

    //                 ld  pt     po     up  st  pa  tk  et     eo     eb     er  ed
    vecs.push_back(mk(1, 4'd3, 4'd5, 0, 0, 0, 0, 4'd3, 4'd5, 7'd35, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 4'd3, 4'd5, 7'd35, 1, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd3, 4'd4, 7'd34, 1, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 0, 0, 1, 1, 4'd3, 4'd4, 7'd34, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd3, 4'd4, 7'd34, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 4'd3, 4'd4, 7'd34, 1, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd3, 4'd3, 7'd33, 1, 0));
    vecs.push_back(mk(1, 4'd1, 4'd0, 0, 0, 0, 1, 4'd1, 4'd0, 7'd10, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 4'd1, 4'd0, 7'd10, 1, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd0, 4'd9, 7'd9, 1, 0));
    vecs.push_back(mk(1, 4'd1, 4'd9, 0, 0, 0, 0, 4'd1, 4'd9, 7'd19, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 1, 1, 0, 0, 4'd1, 4'd9, 7'd19, 1, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd2, 4'd0, 7'd20, 1, 0));
    vecs.push_back(mk(1, 4'd9, 4'd8, 0, 0, 0, 0, 4'd9, 4'd8, 7'd98, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 1, 1, 0, 0, 4'd9, 4'd8, 7'd98, 1, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd9, 4'd9, 7'd99, 0, 1));
    vecs.push_back(mk(1, 4'd12, 4'd15, 0, 0, 0, 0, 4'd9, 4'd9, 7'd99, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 1, 1, 0, 0, 4'd9, 4'd9, 7'd99, 0, 1));
    vecs.push_back(mk(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 4'd0, 7'd0, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 4'd0, 4'd0, 7'd0, 0, 1));

    foreach (vecs[i]) begin
      load = vecs[i].ld; preset_tens = vecs[i].pt; preset_ones = vecs[i].po;
      up_down = vecs[i].up; start = vecs[i].st; pause = vecs[i].pa;
      divided_clk = vecs[i].tk;
      step();
      chk($sformatf("vec%0d tens", i), int'(tens0), int'(vecs[i].et));
      chk($sformatf("vec%0d ones", i), int'(ones0), int'(vecs[i].eo));
      chk($sformatf("vec%0d bin", i), int'(bin0), int'(vecs[i].eb));
      chk($sformatf("vec%0d running", i), int'(run0), int'(vecs[i].er));
      chk($sformatf("vec%0d done", i), int'(done0), int'(vecs[i].ed));
      load = 1'b0; start = 1'b0; pause = 1'b0; divided_clk = 1'b0;
      step();
    end

    // Countdown 02 -> 00: DONE holds without reload, reload restarts from 02
    pulse_load(4'd0, 4'd2);
    pulse_start(1'b0);
    tick_hi();
    chk0("cd 01", 0, 1, 1, 0);
    chk1("cd 01", 0, 1, 1, 0);
    tick_lo();
    tick_hi();
    chk0("cd 00", 0, 0, 0, 1);
    chk1("cd 00", 0, 0, 1, 1);
    step();
    chk("cd done drop", int'(done0), 0);
    chk("cd ar done drop", int'(done1), 0);
    tick_lo();
    tick_hi();
    chk1("ar reload", 0, 2, 1, 0);
    tick_lo();
    for (int k = 0; k < 5; k++) begin
      tick_hi();
      chk0($sformatf("hold%0d", k), 0, 0, 0, 0);
      tick_lo();
    end
    pulse_start(1'b0);
    chk0("hold start", 0, 0, 0, 0);
    step();
    chk("hold start done", int'(done0), 0);

    // Auto-reload from 01 counting down
    pulse_load(4'd0, 4'd1);
    pulse_start(1'b0);
    tick_hi();
    chk1("ar01 00", 0, 0, 1, 1);
    tick_lo();
    tick_hi();
    chk1("ar01 reload", 0, 1, 1, 0);
    tick_lo();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
